// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//
// Round-robin arbiter and sequencer sharing one WIDTH-bit D flip-flop register
// between NREQ requesters.  A granted requester gets one operation: load,
// set all ones, clear to zero, or invert.  The block drives the register's
// synchronous data/set/reset inputs for exactly one clock.  It then pulses
// ack for one cycle.  At all other times it drives hold (ff_data = q_in).
//
// Handshake: a requester raises req[i] with op/wdata already valid and keeps
// them stable until ack[i].  The command is sampled only when the block leaves
// IDLE.  After ack the requester must drop req[i] for at least one cycle
// before it can win again.  Dropping req early (GRANT/EXEC) does not cancel
// the operation.
//
// Ports:
//   clk       in   rising-edge clock, shared with the controlled register
//   reset     in   synchronous active-low reset
//   req       in   [NREQ-1:0]        per-requester request level
//   op        in   [2*NREQ-1:0]      per-requester opcode (00 load, 01 set,
//                                    10 clear, 11 invert), 2 bits each
//   wdata     in   [WIDTH*NREQ-1:0]  per-requester load data, WIDTH bits each
//   q_in      in   [WIDTH-1:0]       current register output
//   ff_data   out  [WIDTH-1:0]       register data input
//   ff_set    out                    register synchronous set
//   ff_reset  out                    register synchronous reset
//   gnt       out  [NREQ-1:0]        one-hot grant (GRANT, EXEC, ACK)
//   ack       out  [NREQ-1:0]        one-hot, one-cycle completion pulse
//   busy      out                    high whenever not IDLE
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [2*NREQ-1:0]       op,
   input  logic [WIDTH*NREQ-1:0]   wdata,
   input  logic [WIDTH-1:0]        q_in,
   output logic [WIDTH-1:0]        ff_data,
   output logic                    ff_set,
   output logic                    ff_reset,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         ack,
   output logic                    busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW:0]   NREQ_W = (PW+1)'(NREQ);
   localparam logic [PW-1:0] LAST   = PW'(NREQ - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_GRANT   = 3'd1;
   localparam logic [2:0] S_EXEC    = 3'd2;
   localparam logic [2:0] S_ACK     = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SET  = 2'b01;
   localparam logic [1:0] OP_CLR  = 2'b10;
   localparam logic [1:0] OP_INV  = 2'b11;

   logic [2:0]       state_q,   state_d;
   logic [NREQ-1:0]  gnt_q,     gnt_d;
   logic [NREQ-1:0]  ack_q,     ack_d;
   logic [PW-1:0]    ptr_q,     ptr_d;
   logic [PW-1:0]    winner_q,  winner_d;
   logic [1:0]       cmd_op_q,  cmd_op_d;
   logic [WIDTH-1:0] cmd_val_q, cmd_val_d;

   logic             found;
   logic [PW-1:0]    win_idx;
   logic [PW:0]      sum;
   logic [1:0]       win_op;
   logic [WIDTH-1:0] win_data;

   // Rotating priority scan: first requester at or above the pointer, wrapping.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      sum     = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= NREQ_W) sum = sum - NREQ_W;
         if (!found && req[sum[PW-1:0]]) begin
            found   = 1'b1;
            win_idx = sum[PW-1:0];
         end
      end
   end

   // Constant-index slice selection keeps the mux free of multiplied indices.
   always_comb begin
      win_op   = OP_LOAD;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == PW'(i)) begin
            win_op   = op[2*i +: 2];
            win_data = wdata[WIDTH*i +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      ack_d     = '0;
      ptr_d     = ptr_q;
      winner_d  = winner_q;
      cmd_op_d  = cmd_op_q;
      cmd_val_d = cmd_val_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d          = S_GRANT;
               gnt_d            = '0;
               gnt_d[win_idx]   = 1'b1;
               winner_d         = win_idx;
               cmd_op_d         = win_op;
               // Invert captures q_in now, so a later async preset/clear
               // does not change what gets written.
               if (win_op == OP_LOAD)     cmd_val_d = win_data;
               else if (win_op == OP_INV) cmd_val_d = ~q_in;
               else                       cmd_val_d = '0;
            end
         end
         S_GRANT: state_d = S_EXEC;
         S_EXEC: begin
            state_d         = S_ACK;
            ack_d[winner_q] = 1'b1;
         end
         S_ACK: begin
            state_d = S_RELEASE;
            gnt_d   = '0;
            ptr_d   = (winner_q == LAST) ? '0 : winner_q + 1'b1;
         end
         S_RELEASE: begin
            if (!req[winner_q]) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         gnt_q     <= '0;
         ack_q     <= '0;
         ptr_q     <= '0;
         winner_q  <= '0;
         cmd_op_q  <= OP_LOAD;
         cmd_val_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ack_q     <= ack_d;
         ptr_q     <= ptr_d;
         winner_q  <= winner_d;
         cmd_op_q  <= cmd_op_d;
         cmd_val_q <= cmd_val_d;
      end
   end

   // Register controls are only active in EXEC; everywhere else hold q.
   always_comb begin
      busy     = (state_q != S_IDLE);
      ff_set   = (state_q == S_EXEC) && (cmd_op_q == OP_SET);
      ff_reset = (state_q == S_EXEC) && (cmd_op_q == OP_CLR);
      if ((state_q == S_EXEC) && ((cmd_op_q == OP_LOAD) || (cmd_op_q == OP_INV)))
         ff_data = cmd_val_q;
      else
         ff_data = q_in;
   end

   assign gnt = gnt_q;
   assign ack = ack_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for reg_write_arbiter.  A behavioural 4-bit register driven by the
// DUT's ff_* outputs feeds q_in back.  Directed transactions from a table,
// hand-written corner sequences, then randomized traffic against a
// transaction-level model.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [2*NREQ-1:0]     op;
   logic [WIDTH*NREQ-1:0] wdata;
   logic [WIDTH-1:0]      q_reg;
   logic [WIDTH-1:0]      ff_data;
   logic                  ff_set, ff_reset, busy;
   logic [NREQ-1:0]       gnt, ack;
   logic                  preload_en;
   logic [WIDTH-1:0]      preload_val;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reg_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
      .q_in(q_reg), .ff_data(ff_data), .ff_set(ff_set), .ff_reset(ff_reset),
      .gnt(gnt), .ack(ack), .busy(busy)
   );

   // The shared register; preload lets the bench establish a starting q.
   always @(posedge clk) begin
      if (preload_en)    q_reg <= preload_val;
      else if (ff_reset) q_reg <= '0;
      else if (ff_set)   q_reg <= '1;
      else               q_reg <= ff_data;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (busy !== 1'b0 && i < 20) begin
         @(negedge clk);
         i++;
      end
      chk("idle_timeout", 32'(busy), 0);
   endtask

   task automatic reset_pulse();
      req   = '0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      int         who;
      logic [1:0] opc;
      logic [3:0] wd;
      logic [3:0] q0;
      logic [3:0] exp_q;
      int         hold;
   } vec_t;

   task automatic run_txn(input vec_t v);
      int oh;
      int rel;
      oh  = 1 << v.who;
      rel = (v.hold > 0) ? v.hold : 1;
      req         = '0;
      preload_en  = 1'b1;
      preload_val = v.q0;
      @(negedge clk);
      preload_en = 1'b0;
      op[2*v.who +: 2]    = v.opc;
      wdata[4*v.who +: 4] = v.wd;
      req[v.who]          = 1'b1;
      @(negedge clk);                       // GRANT
      chk("grant_gnt", 32'(gnt), oh);
      chk("grant_busy", 32'(busy), 1);
      chk("grant_hold_data", 32'(ff_data), 32'(v.q0));
      chk("grant_no_ctl", 32'({ff_set, ff_reset}), 0);
      @(negedge clk);                       // EXEC
      chk("exec_gnt", 32'(gnt), oh);
      chk("exec_set", 32'(ff_set), 32'(v.opc == 2'b01));
      chk("exec_reset", 32'(ff_reset), 32'(v.opc == 2'b10));
      chk("exec_excl", 32'(ff_set & ff_reset), 0);
      if (v.opc == 2'b00 || v.opc == 2'b11) chk("exec_data", 32'(ff_data), 32'(v.exp_q));
      @(negedge clk);                       // ACK
      chk("ack_pulse", 32'(ack), oh);
      chk("ack_gnt", 32'(gnt), oh);
      chk("q_after_exec", 32'(q_reg), 32'(v.exp_q));
      if (v.hold == 0) req[v.who] = 1'b0;
      for (int h = 1; h <= rel; h++) begin  // RELEASE
         @(negedge clk);
         chk("release_busy", 32'(busy), 1);
         chk("release_gnt", 32'(gnt), 0);
         chk("release_no_reack", 32'(ack), 0);
         if (h == v.hold) req[v.who] = 1'b0;
      end
      @(negedge clk);
      chk("back_idle", 32'(busy), 0);
      chk("q_held", 32'(q_reg), 32'(v.exp_q));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      vec_t tbl[8];
      int   order[$];
      int   exp_order[5];
      int   dcnt[NREQ];
      int   ack0_cnt, ack1_cnt;

      tbl[0] = '{2, 2'b00, 4'b1010, 4'b0000, 4'b1010, 0};
      tbl[1] = '{1, 2'b01, 4'b0000, 4'b0101, 4'b1111, 0};
      tbl[2] = '{1, 2'b10, 4'b0000, 4'b1111, 4'b0000, 0};
      tbl[3] = '{1, 2'b11, 4'b0000, 4'b0110, 4'b1001, 0};
      tbl[4] = '{0, 2'b00, 4'b0101, 4'b1100, 4'b0101, 1};
      tbl[5] = '{3, 2'b11, 4'b1111, 4'b0000, 4'b1111, 3};
      tbl[6] = '{3, 2'b01, 4'b0000, 4'b0010, 4'b1111, 0};
      tbl[7] = '{0, 2'b10, 4'b0110, 4'b1010, 4'b0000, 2};

      // Reset held with all requesting: nothing may be granted.
      reset = 1'b0; req = 4'b1111; op = '0; wdata = '0;
      preload_en = 1'b1; preload_val = 4'b0110;
      @(negedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ctl", 32'({ff_set, ff_reset}), 0);
      chk("rst_data_tracks_q", 32'(ff_data), 32'h6);
      reset = 1'b1; preload_en = 1'b0;
      @(negedge clk);
      chk("post_rst_gnt0", 32'(gnt), 1);
      req = '0;
      wait_idle();

      for (int i = 0; i < 8; i++) run_txn(tbl[i]);

      // Round-robin with every requester dropping on its own ack.
      reset_pulse();
      op = '0; wdata = 16'h4321; req = 4'b1111;
      for (int i = 0; i < NREQ; i++) dcnt[i] = 0;
      for (int cyc = 0; cyc < 100 && order.size() < 5; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            if (dcnt[i] > 0) begin
               dcnt[i]--;
               if (dcnt[i] == 0) req[i] = 1'b1;
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
               order.push_back(i);
               req[i]  = 1'b0;
               dcnt[i] = 2;
            end
         end
      end
      exp_order = '{0, 1, 2, 3, 0};
      chk("rr_count", 32'(order.size()), 5);
      for (int i = 0; i < order.size() && i < 5; i++) chk("rr_order", 32'(order[i]), 32'(exp_order[i]));
      req = '0;
      wait_idle();

      // Two holders: 0 is served once, then sits in RELEASE; 1 starves.
      reset_pulse();
      req = 4'b0011;
      ack0_cnt = 0; ack1_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ack[0]) ack0_cnt++;
         if (ack[1]) ack1_cnt++;
      end
      chk("hold_ack0_once", 32'(ack0_cnt), 1);
      chk("hold_ack1_none", 32'(ack1_cnt), 0);
      chk("hold_busy", 32'(busy), 1);
      req = '0;
      wait_idle();

      // Reset during GRANT: pointer is 1 here, and the write must be lost.
      preload_en = 1'b1; preload_val = 4'b0011;
      @(negedge clk);
      preload_en = 1'b0;
      op[5:4] = 2'b00; wdata[11:8] = 4'b0101; req = 4'b0100;
      @(negedge clk);
      chk("mid_grant", 32'(gnt), 4);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_gnt", 32'(gnt), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      reset = 1'b1; req = '0;
      ack0_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ack != 0) ack0_cnt++;
      end
      chk("mid_no_ack", 32'(ack0_cnt), 0);
      chk("mid_q_kept", 32'(q_reg), 32'h3);
      op[1:0] = 2'b00; wdata[3:0] = 4'b0011; req = 4'b0101;
      @(negedge clk);
      chk("mid_restart_ptr0", 32'(gnt), 1);
      req = '0;
      wait_idle();

      // Withdraw in EXEC: operation completes, single RELEASE cycle.
      preload_en = 1'b1; preload_val = 4'b0110;
      @(negedge clk);
      preload_en = 1'b0;
      op[7:6] = 2'b11; req = 4'b1000;
      @(negedge clk);
      chk("wd_grant", 32'(gnt), 8);
      @(negedge clk);
      chk("wd_exec_data", 32'(ff_data), 32'h9);
      req = '0;
      @(negedge clk);
      chk("wd_ack", 32'(ack), 8);
      chk("wd_q", 32'(q_reg), 32'h9);
      @(negedge clk);
      chk("wd_release", 32'(busy), 1);
      @(negedge clk);
      chk("wd_idle", 32'(busy), 0);

      // Randomized traffic against a transaction-level model.
      begin
         int         c, m_active, m_t0, m_w, m_ptr;
         logic [1:0] m_op;
         logic [3:0] m_val, m_q, e_gnt, e_ack, e_data;
         logic       e_exec;
         int         pend[NREQ], dwait[NREQ], hoff[NREQ];
         reset = 1'b0; req = '0;
         preload_en = 1'b1; preload_val = 4'b0000;
         @(negedge clk);
         reset = 1'b1; preload_en = 1'b0;
         c = 0; m_active = 0; m_t0 = 0; m_w = 0; m_ptr = 0;
         m_op = 2'b00; m_val = '0; m_q = 4'b0000;
         for (int i = 0; i < NREQ; i++) begin pend[i] = 0; dwait[i] = 0; hoff[i] = 0; end
         for (int n = 0; n < 2000; n++) begin
            e_gnt  = (m_active != 0 && c >= m_t0 && c <= m_t0 + 2) ? 4'(1 << m_w) : 4'b0;
            e_ack  = (m_active != 0 && c == m_t0 + 2) ? 4'(1 << m_w) : 4'b0;
            e_exec = (m_active != 0 && c == m_t0 + 1);
            e_data = (e_exec && (m_op == 2'b00 || m_op == 2'b11)) ? m_val : m_q;
            chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
            chk("rnd_ack", 32'(ack), 32'(e_ack));
            chk("rnd_busy", 32'(busy), 32'(m_active != 0));
            chk("rnd_set", 32'(ff_set), 32'(e_exec && m_op == 2'b01));
            chk("rnd_reset", 32'(ff_reset), 32'(e_exec && m_op == 2'b10));
            chk("rnd_data", 32'(ff_data), 32'(e_data));
            chk("rnd_q", 32'(q_reg), 32'(m_q));
            // Requesters obeying the contract.
            for (int i = 0; i < NREQ; i++) begin
               if (!req[i]) begin
                  if (hoff[i] > 0) hoff[i]--;
                  else if ($urandom_range(0, 3) == 0) begin
                     op[2*i +: 2]    = 2'($urandom_range(0, 3));
                     wdata[4*i +: 4] = 4'($urandom_range(0, 15));
                     req[i]  = 1'b1;
                     pend[i] = 1;
                  end
               end else if (pend[i] != 0) begin
                  if (ack[i]) begin
                     pend[i]  = 0;
                     dwait[i] = $urandom_range(0, 3);
                  end
               end else if (dwait[i] == 0) begin
                  req[i]  = 1'b0;
                  hoff[i] = 1;
               end else dwait[i]--;
            end
            // Model step for the edge that ends this cycle.
            if (m_active == 0) begin
               if (req != 0) begin
                  for (int k = NREQ - 1; k >= 0; k--)
                     if (req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
                  m_active = 1;
                  m_t0     = c + 1;
                  m_op     = op[2*m_w +: 2];
                  m_val    = (m_op == 2'b00) ? wdata[4*m_w +: 4] : ~m_q;
                  m_ptr    = (m_w + 1) % NREQ;
               end
            end else begin
               if (c == m_t0 + 1) begin
                  case (m_op)
                     2'b01:   m_q = 4'b1111;
                     2'b10:   m_q = 4'b0000;
                     default: m_q = m_val;
                  endcase
               end
               if (c >= m_t0 + 3 && !req[m_w]) m_active = 0;
            end
            c++;
            @(negedge clk);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
